// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage. The delay line lives outside
// the block: fb_data feeds it and fb_ret returns the value written DEPTH cycles earlier.
module r2sdf_bfly_lane #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH:0]   a,
  output logic signed [WIDTH:0]   xe,
  output logic signed [WIDTH:0]   sum,
  output logic signed [WIDTH:0]   dif
);
  // a is always a sign-extended input sample, so WIDTH+1 bits hold a+x and a-x exactly
  assign xe  = {x[WIDTH-1], x};
  assign sum = a + xe;
  assign dif = a - xe;
endmodule

module r2sdf_butterfly_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH-1:0]       in_data,
  output logic [2*(WIDTH+1)-1:0]   fb_data,
  input  logic [2*(WIDTH+1)-1:0]   fb_ret,
  output logic                     out_valid,
  output logic [2*(WIDTH+1)-1:0]   out_data,
  output logic                     out_tw,
  output logic [CNT_W-1:0]         out_idx,
  output logic                     err
);
  localparam int NUM_LANES = 2;  // lane 1 = re, lane 0 = im
  localparam int CW        = WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_BFLY  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pend, pend_nx;
  logic             err_nx, acc, last;

  logic [NUM_LANES-1:0][CW-1:0] x_c, a_c, sum_c, dif_c, fb_c;
  logic                         o_v, o_tw;
  logic [2*CW-1:0]              o_d;
  logic [CNT_W-1:0]             o_idx;

  assign a_c = fb_ret;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      r2sdf_bfly_lane #(.WIDTH(WIDTH)) u_lane (
        .x   (in_data[l*WIDTH +: WIDTH]),
        .a   (a_c[l]),
        .xe  (x_c[l]),
        .sum (sum_c[l]),
        .dif (dif_c[l])
      );
    end
  endgenerate

  // DRAIN only takes a sample in its first cycle, which keeps back-to-back frames seamless
  assign in_ready = (state != S_DRAIN) || (cnt == '0);
  assign acc      = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(DEPTH - 1));
  assign fb_data  = fb_c;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    err_nx   = 1'b0;
    fb_c     = '0;
    o_v      = 1'b0;
    o_d      = '0;
    o_tw     = 1'b0;
    o_idx    = '0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          fb_c     = x_c;
          cnt_nx   = CNT_W'(1);
          state_nx = S_FILL;
        end
      end
      S_FILL: begin
        fb_c = x_c;
        if (acc) begin
          // previous frame's differences stream out while this frame fills
          if (pend) begin
            o_v   = 1'b1;
            o_d   = fb_ret;
            o_tw  = 1'b1;
            o_idx = cnt;
          end
          cnt_nx = cnt + CNT_W'(1);
          if (last) begin
            pend_nx  = 1'b0;
            state_nx = S_BFLY;
          end
        end else begin
          err_nx   = 1'b1;
          pend_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      S_BFLY: begin
        fb_c = dif_c;
        if (acc) begin
          o_v    = 1'b1;
          o_d    = sum_c;
          o_idx  = cnt;
          cnt_nx = cnt + CNT_W'(1);
          if (last) begin
            pend_nx  = 1'b1;
            state_nx = S_DRAIN;
          end
        end else begin
          err_nx   = 1'b1;
          pend_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        o_v   = 1'b1;
        o_d   = fb_ret;
        o_tw  = 1'b1;
        o_idx = cnt;
        if (acc) begin
          fb_c     = x_c;
          cnt_nx   = CNT_W'(1);
          state_nx = S_FILL;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          if (last) begin
            pend_nx  = 1'b0;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tw    <= 1'b0;
      out_idx   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend      <= pend_nx;
      out_valid <= o_v;
      out_data  <= o_d;
      out_tw    <= o_tw;
      out_idx   <= o_idx;
      err       <= err_nx;
    end
  end
endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Bench for r2sdf_butterfly_stage: a cycle timeline of stimulus and expected outputs is
// planned up front from frame-level arithmetic, then replayed and compared every cycle.
module tb_r2sdf_butterfly_stage;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CW    = WIDTH + 1;
  localparam int DW    = 2 * CW;
  localparam int MAXC  = 2048;

  logic             clk = 1'b1;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [2*WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [DW-1:0]    fb_data, fb_ret, out_data;
  logic             out_valid, out_tw, err;
  logic [CNT_W-1:0] out_idx;

  always #5 clk = ~clk;

  r2sdf_butterfly_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fb_data(fb_data), .fb_ret(fb_ret), .out_valid(out_valid),
    .out_data(out_data), .out_tw(out_tw), .out_idx(out_idx), .err(err)
  );

  // external free-running delay line; filled with garbage while reset is low
  logic [DW-1:0] dl [DEPTH];
  assign fb_ret = dl[DEPTH-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) dl[i] <= DW'({$urandom, $urandom});
    end else begin
      dl[0] <= fb_data;
      for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end
  end

  typedef struct {
    int gap; int len; int rst_at;
    int re [2*DEPTH]; int im [2*DEPTH];
    int sre [DEPTH]; int sim [DEPTH]; int dre [DEPTH]; int dim [DEPTH];
  } vec_t;

  bit            s_v [MAXC], s_rst [MAXC];
  bit [31:0]     s_d [MAXC];
  bit            e_v [MAXC], e_err [MAXC], e_zero [MAXC], e_tw [MAXC];
  logic [DW-1:0] e_d [MAXC];
  int            e_idx [MAXC], e_rdy [MAXC];
  int            cur, cyc, n_cmp, n_bad;
  bit            prev_full;
  vec_t          tv [5];

  function automatic logic [DW-1:0] pk(input int r, input int i);
    logic [CW-1:0] a, b;
    a = CW'(r);
    b = CW'(i);
    return {a, b};
  endfunction

  function automatic vec_t mkv(input int gap, input int len, input int rst_at);
    vec_t v;
    v.gap = gap; v.len = len; v.rst_at = rst_at;
    for (int i = 0; i < 2*DEPTH; i++) begin v.re[i] = 0; v.im[i] = 0; end
    for (int k = 0; k < DEPTH; k++) begin v.sre[k] = 0; v.sim[k] = 0; v.dre[k] = 0; v.dim[k] = 0; end
    return v;
  endfunction

  task automatic expect_out(input int c, input logic [DW-1:0] d, input bit tw, input int k);
    e_v[c] = 1'b1; e_d[c] = d; e_tw[c] = tw; e_idx[c] = k;
  endtask

  // Plans one frame: gap idle cycles, then len accepted samples (abort if len < 2*DEPTH),
  // or a 2-cycle reset landing at sample rst_at. Sums/diffs appear one cycle after their operands.
  task automatic plan_frame(input vec_t v);
    int t0, stop;
    for (int i = 0; i < v.gap; i++) begin s_v[cur] = 1'b0; s_d[cur] = $urandom; cur++; end
    t0   = cur;
    stop = (v.rst_at >= 0) ? v.rst_at : v.len;
    if (v.gap == 0 && prev_full && stop < DEPTH)
      for (int k = stop; k < DEPTH; k++) e_v[t0+k+1] = 1'b0;
    for (int i = 0; i < stop; i++) begin
      s_v[cur] = 1'b1; s_d[cur] = {16'(v.re[i]), 16'(v.im[i])}; e_rdy[cur] = 1; cur++;
    end
    for (int k = 0; k < DEPTH; k++)
      if (k + DEPTH < stop && (v.rst_at < 0 || k + DEPTH + 1 < v.rst_at))
        expect_out(t0 + DEPTH + k + 1, pk(v.sre[k], v.sim[k]), 1'b0, k);
    if (v.rst_at >= 0) begin
      for (int c = cur; c < MAXC; c++) begin e_v[c] = 1'b0; e_err[c] = 1'b0; end
      for (int i = 0; i < 2; i++) begin
        s_v[cur] = 1'b1; s_rst[cur] = 1'b1; s_d[cur] = $urandom;
        e_zero[cur] = 1'b1; e_rdy[cur] = 1; cur++;
      end
      prev_full = 1'b0;
    end else if (v.len == 2*DEPTH) begin
      for (int k = 0; k < DEPTH; k++)
        expect_out(t0 + 2*DEPTH + k + 1, pk(v.dre[k], v.dim[k]), 1'b1, k);
      prev_full = 1'b1;
    end else begin
      s_v[cur] = 1'b0; s_d[cur] = $urandom; e_err[cur+1] = 1'b1; cur++;
      prev_full = 1'b0;
    end
  endtask

  // in_valid drops for the first DRAIN cycle, then is held high while the stage refuses it
  task automatic blocked_drain();
    s_v[cur] = 1'b0; cur++;
    for (int i = 0; i < DEPTH-1; i++) begin
      s_v[cur] = 1'b1; s_d[cur] = $urandom; e_rdy[cur] = 0; cur++;
    end
    prev_full = 1'b0;
  endtask

  function automatic vec_t rand_vec(input bit after_full);
    vec_t v;
    logic signed [15:0] r16;
    int gap, len, rst_at;
    if (after_full) gap = ($urandom % 3 == 0) ? 0 : DEPTH + int'($urandom % 3);
    else            gap = int'($urandom % 3);
    len    = ($urandom % 4 == 0) ? 1 + int'($urandom % (2*DEPTH-1)) : 2*DEPTH;
    rst_at = ($urandom % 8 == 0) ? 1 + int'($urandom % (2*DEPTH-1)) : -1;
    v = mkv(gap, len, rst_at);
    for (int i = 0; i < 2*DEPTH; i++) begin
      r16 = 16'($urandom); v.re[i] = int'(r16);
      r16 = 16'($urandom); v.im[i] = int'(r16);
    end
    // reference: first half a, second half x; sums a+x then differences a-x
    for (int k = 0; k < DEPTH; k++) begin
      v.sre[k] = v.re[k] + v.re[k+DEPTH]; v.sim[k] = v.im[k] + v.im[k+DEPTH];
      v.dre[k] = v.re[k] - v.re[k+DEPTH]; v.dim[k] = v.im[k] - v.im[k+DEPTH];
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle(input int n);
    chk("out_valid", 64'(out_valid), 64'(e_v[n]));
    chk("err", 64'(err), 64'(e_err[n]));
    if (e_rdy[n] >= 0) chk("in_ready", 64'(in_ready), 64'(e_rdy[n] != 0));
    if (e_v[n]) begin
      chk("out_data", 64'(out_data), 64'(e_d[n]));
      chk("out_tw", 64'(out_tw), 64'(e_tw[n]));
      chk("out_idx", 64'(out_idx), 64'(e_idx[n]));
    end
    if (e_zero[n]) begin
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_tw", 64'(out_tw), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
    end
  endtask

  initial begin
    vec_t v;
    n_cmp = 0; n_bad = 0; prev_full = 1'b0;
    for (int c = 0; c < MAXC; c++) e_rdy[c] = -1;

    // reset for 3 cycles; cycle 0 is not checked since no edge has yet occurred
    for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
    for (int c = 1; c < 3; c++) begin e_zero[c] = 1'b1; e_rdy[c] = 1; end
    cur = 3;

    // directed frame table
    tv[0] = mkv(0, 8, -1);
    tv[0].re = '{1, 2, 3, 4, 5, 6, 7, 8};
    tv[0].sre = '{6, 8, 10, 12}; tv[0].dre = '{-4, -4, -4, -4};
    tv[1] = mkv(0, 8, -1);
    tv[1].re = '{8, 7, 6, 5, 4, 3, 2, 1};
    tv[1].sre = '{12, 10, 8, 6}; tv[1].dre = '{4, 4, 4, 4};
    tv[2] = mkv(DEPTH, 8, -1);
    tv[2].re = '{-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767};
    tv[2].im = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
    tv[2].sre = '{-1, -1, -1, -1};         tv[2].sim = '{-1, -1, -1, -1};
    tv[2].dre = '{-65535, -65535, -65535, -65535}; tv[2].dim = '{65535, 65535, 65535, 65535};
    tv[3] = tv[0]; tv[3].gap = DEPTH; tv[3].len = 2;
    tv[4] = tv[0];
    for (int i = 0; i < 5; i++) plan_frame(tv[i]);

    // missed first DRAIN cycle, then a clean frame from IDLE
    blocked_drain();
    plan_frame(tv[0]);
    // reset during BFLY of a back-to-back frame, then a clean frame
    v = tv[0]; v.rst_at = DEPTH + 2;
    plan_frame(v);
    plan_frame(tv[0]);

    for (int f = 0; f < 24; f++) plan_frame(rand_vec(prev_full));

    for (int n = 0; n < cur + 2*DEPTH + 4; n++) begin
      cyc      = n;
      rst_n    = !s_rst[n];
      in_valid = s_v[n];
      in_data  = s_d[n];
      @(negedge clk);
      if (n > 0) check_cycle(n);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
